div32_seq: RTL and testbench
============================

Name: div32_seq

Overview:
- Iterative 32-bit unsigned divider: the inverse operation to the combinational 32x32 array multiplier in the ALU.
- Computes quotient Q = A / B and remainder R = A % B with a restoring shift-subtract loop, one quotient bit per clock.
- Sits beside the multiplier under the ALU. Uses a START/BUSY/DONE handshake so the control unit can stall while a divide is in flight.
- Reuses the team's 32-bit add/subtract datapath style; the subtract-and-compare is one 33-bit trial subtraction per cycle.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- START  input  1  request; sampled only when BUSY=0.
- A  input  32  dividend; sampled on the accepting edge.
- B  input  32  divisor; sampled on the accepting edge.
- Q  output  32  quotient, registered.
- R  output  32  remainder, registered.
- BUSY  output  1  high while a division is in progress.
- DONE  output  1  one-cycle pulse: Q/R/DIV_BY_ZERO are valid.
- DIV_BY_ZERO  output  1  set with DONE when B was 0; holds until the next accept.

Behaviour:
- Reset: when RST=1 at a rising edge:
  - Q=0, R=0, BUSY=0, DONE=0, DIV_BY_ZERO=0.
  - Counter=0, state=IDLE.
  - This applies in any state; an in-flight division is abandoned with no DONE pulse.
- States:
  - IDLE: BUSY=0.
  - CALC: BUSY=1.
  - FIN: BUSY=0, DONE=1 for exactly one cycle.
- Accept: at edge k, if state is IDLE or FIN and START=1:
  - Latch A into the dividend shift register and B into the divisor register.
  - Clear the partial remainder (33 bits) and set counter=0.
  - Clear DIV_BY_ZERO.
  - Go to CALC. If the latched B is 0, go to ZERO handling instead (see below).
- START while BUSY=1 is ignored; no queueing.
- CALC step, each edge:
  - Form the trial value {rem[31:0], dvd[31]} - {1'b0, divisor}.
  - If the result is non-negative, rem takes the result and quotient bit = 1.
  - Otherwise rem takes {rem[31:0], dvd[31]} and quotient bit = 0.
  - Shift dvd left by 1 with the quotient bit inserted at bit 0; increment the counter.
- Finish: on the edge where the counter reaches 32 (edge k+32):
  - Q takes dvd, R takes rem[31:0].
  - Go to FIN. DONE is high during the cycle after edge k+32.
- Latency: 33 cycles from the accepting edge to the DONE cycle. BUSY is high for cycles k+1 through k+32.
- FIN → IDLE on the next edge unless a new START is accepted in FIN. Back-to-back operation is legal with no bubble beyond the FIN cycle.
- Q/R hold their values in IDLE until the next completion.
- Divide by zero: B==0 at accept skips CALC.
  - The next edge gives FIN with Q=32'hFFFFFFFF, R=A, DIV_BY_ZERO=1, DONE=1.
  - Latency is 1 cycle.
- Corner cases:
  - A < B gives Q=0, R=A.
  - A=0 gives Q=0, R=0.
  - B=1 gives Q=A, R=0.
  - No overflow is possible in unsigned mode.
- Operands A/B may change freely after the accepting edge.

Optional Feature:
- DIV32_SIGNED_EN: when defined, A/B are two's complement.
  - At accept, latch |A| and |B| plus signA and signB.
  - At finish, Q = (signA^signB) ? -q : q and R = signA ? -r : r. The fix-up is applied on the finishing edge, so latency is unchanged.
  - Special cases:
    - A=32'h80000000, B=32'hFFFFFFFF gives Q=32'h80000000, R=0, DIV_BY_ZERO=0.
    - B=0 gives Q=32'hFFFFFFFF, R=A.
- When the macro is undefined, the block is purely unsigned and has no sign logic.

Test Plan:
- A=100, B=7, START for one cycle → BUSY for 32 cycles; DONE on the 33rd cycle with Q=14, R=2.
- A=32'hFFFFFFFF, B=1 → Q=32'hFFFFFFFF, R=0; then immediately START in the FIN cycle with A=5, B=10 → Q=0, R=5, 33 cycles later.
- A=1234, B=0 → DONE on the next cycle with Q=32'hFFFFFFFF, R=1234, DIV_BY_ZERO=1; the flag clears on the next accept.
- START pulses while BUSY with A=9, B=3 during a run of A=50, B=5 → only Q=10, R=0 is produced; exactly one DONE pulse.
- RST asserted at cycle 10 of a division → next cycle BUSY=0, Q=R=0; no DONE; a fresh START then completes normally.
- With DIV32_SIGNED_EN defined:
  - A=-7 (32'hFFFFFFF9), B=2 → Q=-3 (32'hFFFFFFFD), R=-1.
  - A=32'h80000000, B=-1 → Q=32'h80000000, R=0.

Source files
------------

// File: rtl/div32_seq_if.sv
// div32_seq_if: start/operand/result bundle between the ALU control and div32_seq.
interface div32_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    modport master (output start, a, b, input q, r, busy, done, div_by_zero);
    modport slave (input start, a, b, output q, r, busy, done, div_by_zero);
endinterface

// File: rtl/div32_seq.sv
// div32_seq: iterative restoring divider, one quotient bit per clock, START/BUSY/DONE handshake.
// Optional macro DIV32_SIGNED_EN selects two's-complement operands with sign fix-up at finish.
module div32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic         clk,
    input logic         rst,
    div32_seq_if.slave  d
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd, dvs, rem, rem_n, dvd_n, a_in, b_in, q_fin, r_fin;
    logic [WIDTH:0]   trial;
    logic             qbit, accept;
    assign accept = (state != CALC) && d.start;
    // The partial remainder never reaches the divisor, so its top bit is always zero and is not stored.
    always_comb begin
        trial = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
        qbit  = ~trial[WIDTH];
        rem_n = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
        dvd_n = {dvd[WIDTH-2:0], qbit};
    end
`ifdef DIV32_SIGNED_EN
    logic sa, sb;
    always_comb begin
        a_in  = d.a[WIDTH-1] ? -d.a : d.a;
        b_in  = d.b[WIDTH-1] ? -d.b : d.b;
        q_fin = (sa ^ sb) ? -dvd_n : dvd_n;
        r_fin = sa ? -rem_n : rem_n;
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            sa <= d.a[WIDTH-1];
            sb <= d.b[WIDTH-1];
        end
    end
`else
    always_comb begin
        a_in  = d.a;
        b_in  = d.b;
        q_fin = dvd_n;
        r_fin = rem_n;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            d.q           <= '0;
            d.r           <= '0;
            d.busy        <= 1'b0;
            d.done        <= 1'b0;
            d.div_by_zero <= 1'b0;
        end else begin
            d.done <= 1'b0;
            if (accept) begin
                dvd           <= a_in;
                dvs           <= b_in;
                rem           <= '0;
                cnt           <= '0;
                d.div_by_zero <= 1'b0;
                if (d.b == '0) begin
                    state         <= FIN;
                    d.q           <= '1;
                    d.r           <= d.a;
                    d.div_by_zero <= 1'b1;
                    d.done        <= 1'b1;
                    d.busy        <= 1'b0;
                end else begin
                    state  <= CALC;
                    d.busy <= 1'b1;
                end
            end else if (state == CALC) begin
                rem <= rem_n;
                dvd <= dvd_n;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state  <= FIN;
                    d.busy <= 1'b0;
                    d.done <= 1'b1;
                    d.q    <= q_fin;
                    d.r    <= r_fin;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed scenario tasks for div32_seq with hand-computed quotients and remainders.
module tb_div32_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    div32_seq_if #(.WIDTH(32)) bus ();
    div32_seq #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .d(bus));
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    // Called at a negedge: pulses start across one rising edge, returns at the negedge of cycle k+1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    // Returns the cycle count from accept to done (capped at 40) and how many of those cycles had busy high.
    task automatic wait_done(output int lat, output int nb);
        lat = 1;
        nb = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic test_reset;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++; if (bus.q !== 32'h0) begin bad++; $display("FAIL reset_q: got %h want 0", bus.q); end
        total++; if (bus.r !== 32'h0) begin bad++; $display("FAIL reset_r: got %h want 0", bus.r); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
        @(negedge clk);
    endtask
    task automatic test_basic;
        int lat, nb;
        launch(32'd100, 32'd7);
        bus.a = 32'd1;
        bus.b = 32'd1;
        wait_done(lat, nb);
        total++; if (lat !== 33) begin bad++; $display("FAIL basic_latency: got %0d want 33", lat); end
        total++; if (nb !== 32) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 32", nb); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_fin: got %b want 0", bus.busy); end
        total++; if (bus.q !== 32'd14) begin bad++; $display("FAIL basic_q: got %0d want 14", bus.q); end
        total++; if (bus.r !== 32'd2) begin bad++; $display("FAIL basic_r: got %0d want 2", bus.r); end
        total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz: got %b want 0", bus.div_by_zero); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
        @(negedge clk);
        total++; if (bus.q !== 32'd14 || bus.r !== 32'd2) begin bad++; $display("FAIL basic_hold: got q=%0d r=%0d want 14 2", bus.q, bus.r); end
    endtask
    task automatic test_back_to_back;
        int lat, nb;
        launch(32'hFFFFFFFF, 32'd1);
        wait_done(lat, nb);
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_first_latency: got %0d want 33", lat); end
        total++; if (bus.q !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_first_q: got %h want ffffffff", bus.q); end
        total++; if (bus.r !== 32'h0) begin bad++; $display("FAIL b2b_first_r: got %h want 0", bus.r); end
        launch(32'd5, 32'd10);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_in_fin: busy got %b want 1", bus.busy); end
        wait_done(lat, nb);
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
        total++; if (bus.q !== 32'd0 || bus.r !== 32'd5) begin bad++; $display("FAIL b2b_second_qr: got q=%0d r=%0d want 0 5", bus.q, bus.r); end
        @(negedge clk);
    endtask
    task automatic test_div_zero;
        int lat, nb;
        launch(32'd1234, 32'd0);
        wait_done(lat, nb);
        total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        total++; if (nb !== 0) begin bad++; $display("FAIL dbz_busy_cycles: got %0d want 0", nb); end
        total++; if (bus.q !== 32'hFFFFFFFF) begin bad++; $display("FAIL dbz_q: got %h want ffffffff", bus.q); end
        total++; if (bus.r !== 32'd1234) begin bad++; $display("FAIL dbz_r: got %0d want 1234", bus.r); end
        total++; if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_hold: got done=%b dbz=%b want 0 1", bus.done, bus.div_by_zero); end
        launch(32'd8, 32'd2);
        total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear_on_accept: got %b want 0", bus.div_by_zero); end
        wait_done(lat, nb);
        total++; if (bus.q !== 32'd4 || bus.r !== 32'd0) begin bad++; $display("FAIL dbz_after_qr: got q=%0d r=%0d want 4 0", bus.q, bus.r); end
        @(negedge clk);
    endtask
    task automatic test_busy_ignore;
        int dones;
        logic [31:0] qs, rs;
        dones = 0;
        qs = '0;
        rs = '0;
        launch(32'd50, 32'd5);
        for (int i = 1; i <= 45; i++) begin
            bus.start = (i == 5 || i == 12 || i == 20);
            bus.a = 32'd9;
            bus.b = 32'd3;
            if (bus.done === 1'b1) begin
                dones++;
                qs = bus.q;
                rs = bus.r;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        total++; if (qs !== 32'd10 || rs !== 32'd0) begin bad++; $display("FAIL ignore_qr: got q=%0d r=%0d want 10 0", qs, rs); end
    endtask
    task automatic test_reset_mid;
        int lat, nb, dones;
        launch(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        total++; if (bus.q !== 32'h0 || bus.r !== 32'h0) begin bad++; $display("FAIL rstmid_qr: got q=%h r=%h want 0 0", bus.q, bus.r); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
        launch(32'd77, 32'd7);
        wait_done(lat, nb);
        total++; if (lat !== 33) begin bad++; $display("FAIL rstmid_fresh_latency: got %0d want 33", lat); end
        total++; if (bus.q !== 32'd11 || bus.r !== 32'd0) begin bad++; $display("FAIL rstmid_fresh_qr: got q=%0d r=%0d want 11 0", bus.q, bus.r); end
        @(negedge clk);
    endtask
    task automatic test_corners;
        int lat, nb;
        launch(32'd3, 32'd9);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'd0 || bus.r !== 32'd3) begin bad++; $display("FAIL corner_a_lt_b: got q=%0d r=%0d want 0 3", bus.q, bus.r); end
        launch(32'd0, 32'd5);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'd0 || bus.r !== 32'd0) begin bad++; $display("FAIL corner_a_zero: got q=%0d r=%0d want 0 0", bus.q, bus.r); end
        launch(32'd123457, 32'd1);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'd123457 || bus.r !== 32'd0) begin bad++; $display("FAIL corner_b_one: got q=%0d r=%0d want 123457 0", bus.q, bus.r); end
`ifndef DIV32_SIGNED_EN
        launch(32'hFFFFFFFF, 32'h00010000);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'h0000FFFF || bus.r !== 32'h0000FFFF) begin bad++; $display("FAIL corner_big: got q=%h r=%h want 0000ffff 0000ffff", bus.q, bus.r); end
        launch(32'h80000000, 32'd3);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'd715827882 || bus.r !== 32'd2) begin bad++; $display("FAIL corner_msb: got q=%0d r=%0d want 715827882 2", bus.q, bus.r); end
        launch(32'd7, 32'hFFFFFFFF);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'd0 || bus.r !== 32'd7) begin bad++; $display("FAIL corner_max_b: got q=%0d r=%0d want 0 7", bus.q, bus.r); end
`endif
        @(negedge clk);
    endtask
`ifdef DIV32_SIGNED_EN
    task automatic test_signed;
        int lat, nb;
        launch(32'hFFFFFFF9, 32'd2);
        wait_done(lat, nb);
        total++; if (lat !== 33) begin bad++; $display("FAIL signed_latency: got %0d want 33", lat); end
        total++; if (bus.q !== 32'hFFFFFFFD || bus.r !== 32'hFFFFFFFF) begin bad++; $display("FAIL signed_neg7_2: got q=%h r=%h want fffffffd ffffffff", bus.q, bus.r); end
        launch(32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'h80000000 || bus.r !== 32'h0 || bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL signed_min_neg1: got q=%h r=%h dbz=%b want 80000000 0 0", bus.q, bus.r, bus.div_by_zero); end
        launch(32'd7, 32'hFFFFFFFE);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'hFFFFFFFD || bus.r !== 32'd1) begin bad++; $display("FAIL signed_7_neg2: got q=%h r=%h want fffffffd 1", bus.q, bus.r); end
        launch(32'hFFFFFFF9, 32'd0);
        wait_done(lat, nb);
        total++; if (bus.q !== 32'hFFFFFFFF || bus.r !== 32'hFFFFFFF9) begin bad++; $display("FAIL signed_dbz: got q=%h r=%h want ffffffff fffffff9", bus.q, bus.r); end
        @(negedge clk);
    endtask
`endif
    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_div_zero;
        test_busy_ignore;
        test_reset_mid;
        test_corners;
`ifdef DIV32_SIGNED_EN
        test_signed;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
